ca_net_param: RTL and testbench

CA_NET_PARAM -- requirements
Module: ca_net_param

---
 rtl/ca_net_param.sv | 143 ++++++++++++++
 tb/tb_ca_net_param.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ca_net_param.sv
// Parameterised cellular-automaton net: per-cell LUT rules, serial state load,
// stepped evolution with fixed-point detection and an optional step limit.
module ca_net_param #(
    parameter int N_CELLS = 5,
    parameter int K_IN    = 5,
    parameter int CNT_W   = 16,
    parameter logic [(1<<K_IN)-1:0] RULE_INIT = 32'hA99A9AA5
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [N_CELLS*K_IN-1:0]                     Entrada,
    input  logic [(1<<K_IN)-1:0]                        rule_data,
    input  logic [(N_CELLS>1 ? $clog2(N_CELLS) : 1)-1:0] rule_addr,
    input  logic                                        rule_we,
    input  logic                                        init_bit,
    input  logic                                        init_valid,
    output logic                                        init_ready,
    input  logic                                        start,
    input  logic                                        sync,
    input  logic [CNT_W-1:0]                            max_steps,
    output logic [N_CELLS-1:0]                          Salida,
    output logic [1:0]                                  state,
    output logic [CNT_W-1:0]                            step_cnt,
    output logic                                        stable,
    output logic                                        done
);

    localparam int RULE_W = 1 << K_IN;
    localparam int AW     = (N_CELLS > 1) ? $clog2(N_CELLS) : 1;
    localparam int LW     = $clog2(N_CELLS + 1);

    typedef enum logic [1:0] {
        S_LOAD  = 2'b00,
        S_READY = 2'b01,
        S_RUN   = 2'b10,
        S_HALT  = 2'b11
    } state_t;

    state_t              state_q, state_d;
    logic [N_CELLS-1:0]  sal_q, sal_d, sal_nxt;
    logic [CNT_W-1:0]    cnt_q, cnt_d, cnt_inc;
    logic                stable_q, stable_d;
    logic [LW-1:0]       ld_q, ld_d;
    logic [RULE_W-1:0]   rule_q [N_CELLS];
    logic [RULE_W-1:0]   rule_d [N_CELLS];

    always_comb begin
        sal_nxt = '0;
        for (int i = 0; i < N_CELLS; i++) begin
            sal_nxt[i] = rule_q[i][Entrada[i*K_IN +: K_IN]];
        end
    end

    assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);

    // Out-of-range addresses never match a cell, so they drop silently.
    always_comb begin
        for (int i = 0; i < N_CELLS; i++) begin
            rule_d[i] = rule_q[i];
            if (rule_we && state_q != S_RUN && rule_addr == AW'(i)) begin
                rule_d[i] = rule_data;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        sal_d    = sal_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        ld_d     = ld_q;
        unique case (state_q)
            S_LOAD: begin
                if (init_valid) begin
                    sal_d              = sal_q >> 1;
                    sal_d[N_CELLS-1]   = init_bit;
                    ld_d               = ld_q + LW'(1);
                    if (ld_q == LW'(N_CELLS - 1)) begin
                        state_d = S_READY;
                    end
                end
            end
            S_READY: begin
                if (start) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    stable_d = 1'b0;
                end
            end
            S_RUN: begin
                if (sync) begin
                    sal_d = sal_nxt;
                    cnt_d = cnt_inc;
                    if (sal_nxt == sal_q) begin
                        stable_d = 1'b1;
                        state_d  = S_HALT;
                    end
                    if (max_steps != '0 && cnt_inc == max_steps) begin
                        state_d = S_HALT;
                    end
                end
            end
            S_HALT: begin
                if (start) begin
                    state_d  = S_LOAD;
                    ld_d     = '0;
                    stable_d = 1'b0;
                end
            end
            default: state_d = S_LOAD;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_LOAD;
            sal_q    <= '0;
            cnt_q    <= '0;
            stable_q <= 1'b0;
            ld_q     <= '0;
            for (int i = 0; i < N_CELLS; i++) begin
                rule_q[i] <= RULE_INIT;
            end
        end else begin
            state_q  <= state_d;
            sal_q    <= sal_d;
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
            ld_q     <= ld_d;
            for (int i = 0; i < N_CELLS; i++) begin
                rule_q[i] <= rule_d[i];
            end
        end
    end

    assign Salida     = sal_q;
    assign state      = state_q;
    assign step_cnt   = cnt_q;
    assign stable     = stable_q;
    assign done       = (state_q == S_HALT);
    assign init_ready = (state_q == S_LOAD);

endmodule

// File: tb/tb_ca_net_param.sv
// Directed scoreboard bench for ca_net_param (5 cells, 5 inputs each).
module tb_ca_net_param;

    localparam int N  = 5;
    localparam int K  = 5;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [N*K-1:0] entrada;
    logic [31:0]   rule_data;
    logic [2:0]    rule_addr;
    logic          rule_we;
    logic          init_bit;
    logic          init_valid;
    logic          init_ready;
    logic          start;
    logic          sync;
    logic [CW-1:0] max_steps;
    logic [N-1:0]  salida;
    logic [1:0]    state;
    logic [CW-1:0] step_cnt;
    logic          stable;
    logic          done;

    logic          tog;
    logic [N*K-1:0] ent_fix;

    ca_net_param dut (
        .clk        (clk),
        .reset      (reset),
        .Entrada    (entrada),
        .rule_data  (rule_data),
        .rule_addr  (rule_addr),
        .rule_we    (rule_we),
        .init_bit   (init_bit),
        .init_valid (init_valid),
        .init_ready (init_ready),
        .start      (start),
        .sync       (sync),
        .max_steps  (max_steps),
        .Salida     (salida),
        .state      (state),
        .step_cnt   (step_cnt),
        .stable     (stable),
        .done       (done)
    );

    always #5 clk = ~clk;

    function automatic logic [N*K-1:0] ent_of(input logic t,
                                              input logic [N-1:0] s,
                                              input logic [N*K-1:0] f);
        logic [N*K-1:0] e;
        e = f;
        if (t) begin
            for (int i = 0; i < N; i++) e[i*K +: K] = {s[i], 4'b0000};
        end
        return e;
    endfunction

    // Top index bit of each cell follows its own state when tog is set.
    always_comb entrada = ent_of(tog, salida, ent_fix);

    typedef struct {
        string       tag;
        logic [31:0] v;
    } exp_t;

    exp_t        sbq[$];
    int          vecs = 0;
    int          miss = 0;
    logic [31:0] m_rule [N];
    logic [N-1:0] m_sal;
    int          m_cnt;

    function automatic logic [N-1:0] mnext(input logic [N-1:0] s);
        logic [N-1:0] r;
        logic [N*K-1:0] e;
        logic [31:0] rw;
        e = ent_of(tog, s, ent_fix);
        for (int i = 0; i < N; i++) begin
            rw   = m_rule[i];
            r[i] = rw[e[i*K +: K]];
        end
        return r;
    endfunction

    task automatic push(input string tag, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.v   = v;
        sbq.push_back(e);
    endtask

    task automatic chk(input logic [31:0] obs);
        exp_t e;
        vecs++;
        if (sbq.size() == 0) begin
            miss++;
            $error("FAIL sb_empty observed=%0h", obs);
        end else begin
            e = sbq.pop_front();
            assert (obs === e.v) else begin
                miss++;
                $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.v);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [N-1:0] seq);
        for (int j = 0; j < N; j++) begin
            init_valid = 1'b1;
            init_bit   = seq[j];
            push("load_state", (j == N-1) ? 32'd1 : 32'd0);
            tick();
            chk(32'(state));
        end
        init_valid = 1'b0;
        m_sal = seq;
        push("load_salida", 32'(seq));
        push("load_init_ready", 32'd0);
        chk(32'(salida));
        chk(32'(init_ready));
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d,
                      input logic apply);
        rule_we   = 1'b1;
        rule_addr = a;
        rule_data = d;
        tick();
        rule_we = 1'b0;
        if (apply && a < 3'(N)) m_rule[a] = d;
    endtask

    task automatic go_run();
        start = 1'b1;
        push("run_state", 32'd2);
        push("run_cnt", 32'd0);
        push("run_stable", 32'd0);
        tick();
        start = 1'b0;
        m_cnt = 0;
        chk(32'(state));
        chk(32'(step_cnt));
        chk(32'(stable));
    endtask

    task automatic halt_to_load();
        start = 1'b1;
        push("h2l_state", 32'd0);
        push("h2l_init_ready", 32'd1);
        push("h2l_stable", 32'd0);
        tick();
        start = 1'b0;
        chk(32'(state));
        chk(32'(init_ready));
        chk(32'(stable));
    endtask

    // One RUN cycle; the model decides stability and step-limit halting.
    task automatic run_cycle(input logic s);
        logic [N-1:0] nx;
        logic         st;
        logic         halt;
        sync = s;
        st   = 1'b0;
        halt = 1'b0;
        if (s) begin
            nx    = mnext(m_sal);
            st    = (nx == m_sal);
            m_sal = nx;
            m_cnt++;
            halt  = st || (max_steps != 0 && m_cnt == int'(max_steps));
        end
        push("step_salida", 32'(m_sal));
        push("step_cnt", 32'(m_cnt));
        push("step_state", halt ? 32'd3 : 32'd2);
        push("step_stable", 32'(st));
        push("step_done", 32'(halt));
        tick();
        sync = 1'b0;
        chk(32'(salida));
        chk(32'(step_cnt));
        chk(32'(state));
        chk(32'(stable));
        chk(32'(done));
    endtask

    initial begin
        reset      = 1'b1;
        init_valid = 1'b0;
        init_bit   = 1'b0;
        start      = 1'b0;
        sync       = 1'b0;
        rule_we    = 1'b0;
        rule_addr  = '0;
        rule_data  = '0;
        max_steps  = '0;
        tog        = 1'b0;
        ent_fix    = '0;
        m_sal      = '0;
        m_cnt      = 0;
        for (int i = 0; i < N; i++) m_rule[i] = 32'hA99A9AA5;

        push("rst_state", 32'd0);
        push("rst_salida", 32'd0);
        push("rst_init_ready", 32'd1);
        push("rst_done", 32'd0);
        push("rst_cnt", 32'd0);
        push("rst_stable", 32'd0);
        tick();
        reset = 1'b0;
        chk(32'(state));
        chk(32'(salida));
        chk(32'(init_ready));
        chk(32'(done));
        chk(32'(step_cnt));
        chk(32'(stable));

        load(5'b01010);

        init_valid = 1'b1;
        init_bit   = 1'b1;
        push("ready_ign_salida", 32'(5'b01010));
        push("ready_ign_state", 32'd1);
        tick();
        init_valid = 1'b0;
        chk(32'(salida));
        chk(32'(state));

        for (int i = 0; i < N; i++) wr(3'(i), 32'hFFFFFFFF, 1'b1);
        go_run();
        run_cycle(1'b1);
        run_cycle(1'b1);

        sync = 1'b1;
        push("halt_hold_salida", 32'(m_sal));
        push("halt_hold_cnt", 32'd2);
        push("halt_hold_stable", 32'd1);
        tick();
        sync = 1'b0;
        chk(32'(salida));
        chk(32'(step_cnt));
        chk(32'(stable));

        halt_to_load();
        for (int i = 0; i < N; i++) wr(3'(i), 32'h0000FFFF, 1'b1);
        wr(3'd5, 32'hFFFFFFFF, 1'b1);
        load(5'b00000);
        tog       = 1'b1;
        max_steps = 16'd4;
        go_run();
        for (int k = 0; k < 4; k++) run_cycle(1'b1);

        halt_to_load();
        load(5'b00000);
        go_run();
        run_cycle(1'b1);
        rule_we   = 1'b1;
        rule_addr = 3'd0;
        rule_data = 32'hFFFFFFFF;
        run_cycle(1'b0);
        rule_we = 1'b0;
        run_cycle(1'b1);
        run_cycle(1'b0);

        reset = 1'b1;
        push("midrun_rst_state", 32'd0);
        push("midrun_rst_salida", 32'd0);
        push("midrun_rst_cnt", 32'd0);
        push("midrun_rst_stable", 32'd0);
        push("midrun_rst_init_ready", 32'd1);
        tick();
        reset = 1'b0;
        chk(32'(state));
        chk(32'(salida));
        chk(32'(step_cnt));
        chk(32'(stable));
        chk(32'(init_ready));
        for (int i = 0; i < N; i++) m_rule[i] = 32'hA99A9AA5;

        load(5'b00000);
        max_steps = 16'd2;
        go_run();
        run_cycle(1'b1);
        run_cycle(1'b1);
        halt_to_load();

        for (int i = 0; i < N; i++) wr(3'(i), 32'hFFFFFFFF, 1'b1);
        load(5'b11111);
        max_steps = 16'd1;
        go_run();
        run_cycle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
        $finish;
    end

endmodule
